// File: rtl/decode_sdiv_69s_30s_40_seq.sv
// Sequential radix-2 restoring signed divider with start/done handshake and clock enable.
// Build option: define DECODE_SDIV_REM_EN to implement the signed remainder output (rem is 0 otherwise).
module decode_sdiv_69s_30s_40_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 69,
   parameter int din1_WIDTH = 30,
   parameter int dout_WIDTH = 40
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  dbz
);
   localparam int unsigned AW = din0_WIDTH;
   localparam int unsigned BW = din1_WIDTH;
   localparam int unsigned QW = dout_WIDTH;
   // ID is an instance tag only; it is referenced here without affecting the width
   localparam int unsigned CW = $clog2(AW + 1) + ((ID < 0) ? 0 : 0);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

   state_t        state, state_nxt;
   logic          load, step, fin;
   logic [CW-1:0] cnt;
   logic [AW-1:0] dvd;      // dividend magnitude; quotient bits enter at the LSB
   logic [BW-1:0] dsr;
   logic [BW:0]   part;
   logic          qsign, dbz_q;
   logic [BW:0]   trial, diff;
   logic          borrow;
   logic [QW-1:0] quo_fix;
   logic          unused_part_msb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state and datapath strobes; ce low freezes everything
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      if (ce) begin
         case (state)
            S_IDLE: if (start) begin
               load      = 1'b1;
               state_nxt = S_CALC;
            end
            S_CALC: if (cnt == '0) begin
               fin       = 1'b1;
               state_nxt = S_SIGN;
            end else begin
               step = 1'b1;
            end
            S_SIGN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Shift-in of the next dividend bit, trial subtract and quotient sign fix
   always_comb begin
      trial           = {part[BW-1:0], dvd[AW-1]};
      {borrow, diff}  = {1'b0, trial} - {2'b00, dsr};
      quo_fix         = qsign ? QW'(-dvd[QW-1:0]) : dvd[QW-1:0];
   end

   assign unused_part_msb = part[BW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         dvd   <= '0;
         dsr   <= '0;
         part  <= '0;
         qsign <= 1'b0;
         dbz_q <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= '0;
         dbz   <= 1'b0;
      end else begin
         if (ce) begin
            busy <= (state_nxt == S_CALC);
            done <= (state_nxt == S_SIGN);
         end
         if (load) begin
            dvd   <= din0[AW-1] ? AW'(-din0) : din0;
            dsr   <= din1[BW-1] ? BW'(-din1) : din1;
            part  <= '0;
            qsign <= din0[AW-1] ^ din1[BW-1];
            dbz_q <= (din1 == '0);
            cnt   <= CW'(AW);
         end
         if (step) begin
            part <= borrow ? trial : diff;
            dvd  <= {dvd[AW-2:0], ~borrow};
            cnt  <= cnt - CW'(1);
         end
         // Results land on entry to SIGN so done and the new values coincide
         if (fin) begin
            dout <= dbz_q ? '1 : quo_fix;
            dbz  <= dbz_q;
         end
      end
   end

`ifdef DECODE_SDIV_REM_EN
   logic rsign;

   // Remainder takes the sign of the dividend
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsign <= 1'b0;
         rem   <= '0;
      end else begin
         if (load) rsign <= din0[AW-1];
         if (fin)  rem   <= rsign ? BW'(-part[BW-1:0]) : part[BW-1:0];
      end
   end
`else
   assign rem = '0;
`endif

endmodule
